// File: rtl/fu_pattern_checker.sv
// Pattern player/checker: feeds operand/instruction words to a functional unit and
// compares its results, aligned to the FU pipeline latency, against expected values.
module fu_pattern_checker #(
   parameter int DATA_WIDTH   = 16,
   parameter int INS_WIDTH    = 5,
   parameter int FU_LATENCY   = 1,
   parameter int NUM_PATTERNS = 320
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    pat_valid,
   output logic                    pat_ready,
   input  logic [3*DATA_WIDTH+7:0] pat_data,
   output logic [DATA_WIDTH-1:0]   fu_A,
   output logic [DATA_WIDTH-1:0]   fu_B,
   output logic [INS_WIDTH-1:0]    fu_instruction,
   input  logic [DATA_WIDTH-1:0]   fu_F,
   output logic                    mismatch,
   output logic [15:0]             err_cnt,
   output logic [15:0]             first_err_idx,
   output logic [DATA_WIDTH-1:0]   first_err_got,
   output logic [DATA_WIDTH-1:0]   first_err_exp,
   output logic                    done,
   output logic                    pass
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam int          DEPTH    = FU_LATENCY + 1;
   localparam logic [16:0] NPAT     = 17'(NUM_PATTERNS);
   localparam logic [16:0] LAST_IDX = 17'(NUM_PATTERNS - 1);

   logic [1:0]            state;
   logic [16:0]           acc_idx;
   logic [DEPTH-1:0]      pipe_tag;
   logic [DATA_WIDTH-1:0] pipe_exp [DEPTH];
   logic [15:0]           pipe_idx [DEPTH];
   logic                  xfer;
   logic                  run_start;
   logic                  tail_bad;

   assign pat_ready = (state == S_RUN) && (acc_idx < NPAT);
   assign xfer      = pat_valid && pat_ready;
   assign run_start = start && ((state == S_IDLE) || (state == S_DONE));
   assign tail_bad  = pipe_tag[DEPTH-1] && (fu_F != pipe_exp[DEPTH-1]);
   assign done      = (state == S_DONE);
   assign pass      = done && (err_cnt == 16'd0);

   // Instruction bits above INS_WIDTH carry no meaning for the FU.
   generate
      if (INS_WIDTH < 8) begin : g_ins_pad
         logic ins_unused;
         assign ins_unused = ^pat_data[DATA_WIDTH+INS_WIDTH +: 8-INS_WIDTH];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         acc_idx <= 17'd0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state   <= S_RUN;
                  acc_idx <= 17'd0;
               end
            end
            S_RUN: begin
               if (xfer) begin
                  acc_idx <= acc_idx + 17'd1;
                  if (acc_idx == LAST_IDX) state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (pipe_tag == '0) state <= S_DONE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fu_A           <= '0;
         fu_B           <= '0;
         fu_instruction <= '0;
      end else if (xfer) begin
         fu_A           <= pat_data[2*DATA_WIDTH+8 +: DATA_WIDTH];
         fu_B           <= pat_data[DATA_WIDTH+8 +: DATA_WIDTH];
         fu_instruction <= pat_data[DATA_WIDTH +: INS_WIDTH];
      end
   end

   // The tag marks real patterns; the tail stage lines up with fu_F.
   always_ff @(posedge clk) begin
      if (rst) begin
         pipe_tag <= '0;
      end else begin
         for (int i = DEPTH - 1; i > 0; i--) pipe_tag[i] <= pipe_tag[i-1];
         pipe_tag[0] <= xfer;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
         pipe_exp[i] <= pipe_exp[i-1];
         pipe_idx[i] <= pipe_idx[i-1];
      end
      pipe_exp[0] <= pat_data[DATA_WIDTH-1:0];
      pipe_idx[0] <= acc_idx[15:0];
   end

   always_ff @(posedge clk) begin
      if (rst || run_start) begin
         mismatch      <= 1'b0;
         err_cnt       <= 16'd0;
         first_err_idx <= 16'd0;
         first_err_got <= '0;
         first_err_exp <= '0;
      end else begin
         mismatch <= tail_bad;
         if (tail_bad) begin
            if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            if (err_cnt == 16'd0) begin
               first_err_idx <= pipe_idx[DEPTH-1];
               first_err_got <= fu_F;
               first_err_exp <= pipe_exp[DEPTH-1];
            end
         end
      end
   end

endmodule

// File: tb/tb_fu_pattern_checker.sv
// Randomized scoreboard bench for fu_pattern_checker with a behavioural FU model
// whose latency can be switched to provoke alignment errors.
module tb_fu_pattern_checker;

   localparam int DW  = 16;
   localparam int IW  = 5;
   localparam int LAT = 1;
   localparam int NP  = 5;

   typedef struct {
      int          due;
      bit          mis;
      logic [15:0] err;
   } sb_t;

   logic            clk = 1'b0;
   logic            rst, start, pat_valid, pat_ready, mismatch, done, pass;
   logic [3*DW+7:0] pat_data;
   logic [DW-1:0]   fu_A, fu_B, fu_F, first_err_got, first_err_exp;
   logic [IW-1:0]   fu_instruction;
   logic [15:0]     err_cnt, first_err_idx;
   logic [DW-1:0]   r1, r2;

   int  lat_fu = 1;
   int  cyc    = 0;
   int  total  = 0;
   int  bad    = 0;
   sb_t sbq[$];

   logic [15:0] m_err, m_fidx, m_fgot, m_fexp;
   logic [15:0] last_a, last_b, last_res;
   logic [7:0]  last_ins;

   function automatic logic [15:0] fuOp(input logic [15:0] a, input logic [15:0] b,
                                        input logic [4:0] op);
      case (op)
         5'd0:    return a + b;
         5'd1:    return a - b;
         5'd2:    return a & b;
         5'd3:    return a | b;
         5'd4:    return a ^ b;
         default: return a;
      endcase
   endfunction

   fu_pattern_checker #(
      .DATA_WIDTH(DW), .INS_WIDTH(IW), .FU_LATENCY(LAT), .NUM_PATTERNS(NP)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .pat_valid(pat_valid), .pat_ready(pat_ready),
      .pat_data(pat_data), .fu_A(fu_A), .fu_B(fu_B), .fu_instruction(fu_instruction),
      .fu_F(fu_F), .mismatch(mismatch), .err_cnt(err_cnt), .first_err_idx(first_err_idx),
      .first_err_got(first_err_got), .first_err_exp(first_err_exp), .done(done), .pass(pass)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // FU stand-in: one register stage normally, two when provoking a latency error.
   always @(posedge clk) begin
      r1 <= fuOp(fu_A, fu_B, fu_instruction);
      r2 <= r1;
   end
   assign fu_F = (lat_fu == 2) ? r2 : r1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   initial begin : monitor
      sb_t e;
      forever begin
         @(negedge clk);
         while (sbq.size() > 0 && sbq[0].due < cyc) begin
            checkOutput("missed_compare", 32'(sbq[0].due), 32'(cyc));
            void'(sbq.pop_front());
         end
         if (sbq.size() > 0 && sbq[0].due == cyc) begin
            e = sbq.pop_front();
            checkOutput("mismatch_pulse", 32'(mismatch), 32'(e.mis));
            checkOutput("err_cnt_live", 32'(err_cnt), 32'(e.err));
         end else if (mismatch) begin
            checkOutput("spurious_mismatch", 32'(mismatch), 32'(1'b0));
         end
      end
   end

   // One run of NP patterns; gap_mode 0=back-to-back, 1=valid 1,0,0 repeating, 2=random.
   task automatic applyStimulus(input int run, input int gap_mode, input int corrupt_idx,
                                input bit abort_in_drain);
      int          sent, step, guard, k_last;
      bit          vld, mis;
      logic [15:0] a, b, res, expv, got;
      logic [7:0]  ins;
      sb_t         e;
      sent = 0; step = 0; guard = 0; k_last = cyc;
      start     = 1'b1;
      pat_valid = 1'b1;
      pat_data  = {16'h0001, 16'h0001, 8'h00, 16'h0000};
      checkOutput("ready_before_start", 32'(pat_ready), 32'(1'b0));
      @(negedge clk);
      start  = 1'b0;
      m_err  = 16'd0; m_fidx = 16'd0; m_fgot = 16'd0; m_fexp = 16'd0;
      checkOutput("err_cleared_on_start", 32'(err_cnt), 32'(16'd0));
      checkOutput("done_cleared_on_start", 32'(done), 32'(1'b0));
      while (sent < NP && guard < 100) begin
         guard++;
         case (gap_mode)
            0:       vld = 1'b1;
            1:       vld = (step % 3) == 0;
            default: vld = $urandom_range(0, 1) == 1;
         endcase
         step++;
         if (vld) begin
            if (run == 0 && sent == 0) begin
               a = 16'd100; b = 16'hFF37; ins = 8'h00;
            end else if (run == 1 && sent == 2) begin
               a = 16'd5; b = 16'd5; ins = 8'h01;
            end else begin
               a = 16'($urandom); b = 16'($urandom);
               ins = {3'($urandom), 5'($urandom_range(0, 5))};
            end
            res  = fuOp(a, b, ins[4:0]);
            expv = (sent == corrupt_idx) ? (res ^ 16'h0001) : res;
            got  = (lat_fu == 2) ? last_res : res;
            mis  = (got != expv);
            pat_valid = 1'b1;
            pat_data  = {a, b, ins, expv};
            checkOutput("pat_ready_in_run", 32'(pat_ready), 32'(1'b1));
            if (pat_ready) begin
               if (mis) begin
                  if (m_err == 16'd0) begin
                     m_fidx = 16'(sent); m_fgot = got; m_fexp = expv;
                  end
                  if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
               end
               e.due = cyc + 2 + LAT; e.mis = mis; e.err = m_err;
               sbq.push_back(e);
               last_a = a; last_b = b; last_ins = ins; last_res = res;
               k_last = cyc + 1;
               sent++;
            end
         end else begin
            pat_valid = 1'b0;
            pat_data  = 56'($urandom);
            checkOutput("fu_A_hold", 32'(fu_A), 32'(last_a));
            checkOutput("fu_ins_hold", 32'(fu_instruction), 32'(last_ins[4:0]));
         end
         @(negedge clk);
      end
      pat_valid = 1'b0;
      if (sent < NP) checkOutput("run_timeout", 32'(sent), 32'(NP));
      checkOutput("ready_after_last", 32'(pat_ready), 32'(1'b0));
      checkOutput("fu_B_last", 32'(fu_B), 32'(last_b));
      if (abort_in_drain) begin
         rst = 1'b1;
         while (sbq.size() > 0 && sbq[sbq.size()-1].due > cyc) void'(sbq.pop_back());
         @(negedge clk);
         checkOutput("abort_pat_ready", 32'(pat_ready), 32'(1'b0));
         checkOutput("abort_done", 32'(done), 32'(1'b0));
         checkOutput("abort_pass", 32'(pass), 32'(1'b0));
         checkOutput("abort_err_cnt", 32'(err_cnt), 32'(16'd0));
         checkOutput("abort_fu_A", 32'(fu_A), 32'(16'd0));
         checkOutput("abort_first_idx", 32'(first_err_idx), 32'(16'd0));
         rst = 1'b0;
         last_a = 16'd0; last_b = 16'd0; last_ins = 8'd0; last_res = 16'd0;
         repeat (3) @(negedge clk);
         checkOutput("abort_no_residual_err", 32'(err_cnt), 32'(16'd0));
      end else begin
         while (cyc < k_last + 1 + LAT) @(negedge clk);
         checkOutput("done_not_early", 32'(done), 32'(1'b0));
         @(negedge clk);
         checkOutput("done_on_time", 32'(done), 32'(1'b1));
         checkOutput("pass", 32'(pass), 32'(m_err == 16'd0));
         checkOutput("err_cnt_final", 32'(err_cnt), 32'(m_err));
         checkOutput("first_err_idx", 32'(first_err_idx), 32'(m_fidx));
         checkOutput("first_err_got", 32'(first_err_got), 32'(m_fgot));
         checkOutput("first_err_exp", 32'(first_err_exp), 32'(m_fexp));
         @(negedge clk);
         checkOutput("done_held", 32'(done), 32'(1'b1));
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; pat_valid = 1'b0; pat_data = '0;
      last_a = 16'd0; last_b = 16'd0; last_ins = 8'd0; last_res = 16'd0;
      repeat (3) @(negedge clk);
      checkOutput("reset_pat_ready", 32'(pat_ready), 32'(1'b0));
      checkOutput("reset_mismatch", 32'(mismatch), 32'(1'b0));
      checkOutput("reset_done", 32'(done), 32'(1'b0));
      checkOutput("reset_pass", 32'(pass), 32'(1'b0));
      checkOutput("reset_err_cnt", 32'(err_cnt), 32'(16'd0));
      checkOutput("reset_fu_A", 32'(fu_A), 32'(16'd0));
      checkOutput("reset_fu_ins", 32'(fu_instruction), 32'(5'd0));
      checkOutput("reset_first_exp", 32'(first_err_exp), 32'(16'd0));
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("idle_ready", 32'(pat_ready), 32'(1'b0));

      applyStimulus(0, 0, -1, 1'b0);
      applyStimulus(1, 0, 2, 1'b0);
      applyStimulus(2, 1, -1, 1'b0);
      lat_fu = 2;
      applyStimulus(3, 0, -1, 1'b0);
      lat_fu = 1;
      applyStimulus(4, 2, NP - 1, 1'b1);
      applyStimulus(5, 0, -1, 1'b0);
      applyStimulus(6, 2, 3, 1'b0);
      applyStimulus(7, 2, -1, 1'b0);

      repeat (4) @(negedge clk);
      if (sbq.size() != 0) checkOutput("scoreboard_empty", 32'(sbq.size()), 32'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d required below 10000", cyc);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/fu_pattern_checker.md
# fu_pattern_checker

Synthesizable pattern player/checker that drives the functional unit under test and verifies its result stream in hardware. It accepts a stream of packed pattern words (operand A, operand B, instruction, expected result), applies each to the FU's operand/instruction inputs, aligns the expected result with the FU's pipeline latency, and compares it against `F_o`. It sits between a pattern ROM/loader and the FU, and reports error count, first-failure details and a pass/done verdict.

## Interface
- `DATA_WIDTH`, 16, operand/result width
- `INS_WIDTH`, 5, instruction width driven to the FU
- `FU_LATENCY`, 1, register stages inside the FU (0..7)
- `NUM_PATTERNS`, 320, patterns per run (1..65535)
- `clk`  in  1  clock; one clock; reset is synchronous and active-high
- `rst`  in  1  synchronous active-high reset
- `start`  in  1  begins a run (honoured in IDLE and DONE)
- `pat_valid`  in  1  pattern word valid
- `pat_ready`  out  1  checker accepts pattern this cycle
- `pat_data`  in  3*DATA_WIDTH+8  {A, B, ins[7:0], expected}, A in MSBs
- `fu_A`, `fu_B`  out  DATA_WIDTH  registered operands to FU
- `fu_instruction`  out  INS_WIDTH  registered, = ins[INS_WIDTH-1:0]
- `fu_F`  in  DATA_WIDTH  FU result (`F_o`)
- `mismatch`  out  1  one-cycle pulse per failing compare
- `err_cnt`  out  16  failing compares this run, saturates at 0xFFFF
- `first_err_idx`  out  16  pattern index of first failure
- `first_err_got`, `first_err_exp`  out  DATA_WIDTH  result/expected of first failure
- `done`  out  1  run complete, held
- `pass`  out  1  done && err_cnt==0

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: pat_ready=0. start -> RUN; clears err_cnt, first_err_*, accept/compare indices.
- RUN: pat_ready=1 while accept index < NUM_PATTERNS. Transfer = pat_valid && pat_ready at a rising edge. On transfer: fu_A/fu_B/fu_instruction load from pat_data; expected value, index and valid tag enter an alignment pipeline of depth FU_LATENCY+1. No transfer -> fu_* hold, bubble (tag 0) enters pipeline.
- Transfer of pattern NUM_PATTERNS-1 -> DRAIN (pat_ready=0 from next cycle).
- DRAIN: continue shifting bubbles; when no valid tag remains in pipeline (including the final compare) -> DONE.
- DONE: done=1, pass valid, pat_ready=0; outputs held. start -> RUN as from IDLE.
- Compare: at pipeline tail with tag=1, fu_F sampled and compared bit-exact with expected. Mismatch -> mismatch pulse, err_cnt+1 (saturating); if first failure of run, capture index, fu_F, expected.
- Instruction field bits [7:INS_WIDTH] ignored.
- start in RUN/DRAIN ignored.

## Timing
- Reset (rst=1 at edge): state IDLE; pat_ready, mismatch, done, pass = 0; fu_A, fu_B, fu_instruction, err_cnt, first_err_* = 0; pipeline tags cleared. Reset mid-run aborts; no residual compares.
- Pattern transferred at edge k: fu_* change right after edge k; fu_F sampled at edge k+1+FU_LATENCY; mismatch high and err_cnt updated in cycle following that edge.
- Back-to-back transfers sustain one pattern/cycle; bubbles never compared.
- done rises the cycle after the last pattern's compare edge, i.e. edge k_last+2+FU_LATENCY.
- start and transfer in same cycle from IDLE: start only; first transfer possible next cycle.
- err_cnt at 0xFFFF stays; mismatch still pulses.

## Test plan
- Reset then start, 4 patterns back-to-back, FU model correct (A=100, B=-201, add -> -101 = 0xFF9B) -> pat_ready drops after 4th, err_cnt=0, done and pass =1 at k_last+3 (FU_LATENCY=1).
- Corrupt expected of pattern 2 of 5 (exp 0x0001, FU gives 0x0000) -> single mismatch pulse at edge k2+2, err_cnt=1, first_err_idx=2, got=0x0000, exp=0x0001, pass=0.
- pat_valid toggled 1,0,0,1,... with NUM_PATTERNS=3 -> fu_* hold during gaps, exactly 3 compares, done only after third.
- FU_LATENCY=0 and 3 with matching FU models -> zero errors; wrong latency model (off by one) -> errors on every changing result.
- rst asserted during DRAIN -> all outputs 0 next cycle, state IDLE; subsequent start/run of 2 patterns -> err_cnt reflects only new run.
- In DONE with err_cnt=1, start -> counters cleared, new clean run ends pass=1.
